// File: rtl/register_file.sv
// Eight 16-bit registers (R1..R4, S1..S4) sharing one write-data bus and one
// operation code, with two independent combinational read ports.
module register_file (
  input  logic        i_clk,
  input  logic        i_rstN,
  input  logic [15:0] i_data,
  input  logic [3:0]  i_regSel,
  input  logic [3:0]  i_scrSel,
  input  logic [2:0]  i_funSel,
  input  logic [2:0]  i_outASel,
  input  logic [2:0]  i_outBSel,
  output logic [15:0] o_outA,
  output logic [15:0] o_outB
);

  typedef enum logic [2:0] {
    FUN_DEC      = 3'b000,
    FUN_INC      = 3'b001,
    FUN_LOAD     = 3'b010,
    FUN_CLEAR    = 3'b011,
    FUN_CLR_LOW  = 3'b100,
    FUN_LOW_BYTE = 3'b101,
    FUN_HIGH_BYTE= 3'b110,
    FUN_SEXT_LOW = 3'b111
  } funSel_t;

  // Index 0..3 = R1..R4, 4..7 = S1..S4, matching the read-select encoding.
  logic [15:0] r_regs [8];
  logic [7:0]  w_en;

  // Bit 7 is R1's enable and bit 0 is S4's, so register k uses w_en[7-k].
  assign w_en = {i_regSel, i_scrSel};

  function automatic logic [15:0] applyFun(
    input logic [2:0]  fun,
    input logic [15:0] q,
    input logic [15:0] d
  );
    logic [15:0] result;
    result = q;
    case (funSel_t'(fun))
      FUN_DEC:       result = q - 16'd1;
      FUN_INC:       result = q + 16'd1;
      FUN_LOAD:      result = d;
      FUN_CLEAR:     result = 16'h0000;
      FUN_CLR_LOW:   result = {8'h00, d[7:0]};
      FUN_LOW_BYTE:  result = {q[15:8], d[7:0]};
      FUN_HIGH_BYTE: result = {d[7:0], q[7:0]};
      FUN_SEXT_LOW:  result = {{8{d[7]}}, d[7:0]};
      default:       result = q;
    endcase
    return result;
  endfunction

  for (genvar k = 0; k < 8; k++) begin : g_reg
    always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
        r_regs[k] <= 16'h0000;
      end else if (w_en[7-k]) begin
        r_regs[k] <= applyFun(i_funSel, r_regs[k], i_data);
      end
    end
  end

  assign o_outA = r_regs[i_outASel];
  assign o_outB = r_regs[i_outBSel];

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 16 bits.
REQ-002 Clock  input  1  rising-edge clock for all register updates.
REQ-003 Reset  input  1  asynchronous, active-low reset; low clears all registers immediately.
REQ-004 I  input  16  write data shared by all registers.
REQ-005 RegSel  input  4  per-register enable for R1..R4; bit 3 = R1, bit 0 = R4; 1 = enabled.
REQ-006 ScrSel  input  4  per-register enable for S1..S4; bit 3 = S1, bit 0 = S4; 1 = enabled.
REQ-007 FunSel  input  3  operation applied to every enabled register.
REQ-008 OutASel  input  3  source select for OutA.
REQ-009 OutBSel  input  3  source select for OutB.
REQ-010 OutA  output  16  combinational read port A.
REQ-011 OutB  output  16  combinational read port B.

Function
REQ-012 The block SHALL hold eight 16-bit registers: general R1..R4 and scratch S1..S4.
REQ-013 Each register SHALL update only on a rising Clock edge, and only when its RegSel/ScrSel bit is 1; disabled registers hold their value.
REQ-014 FunSel 000 SHALL decrement: Q <= Q - 1, modulo 2^16 (0000 -> FFFF).
REQ-015 FunSel 001 SHALL increment: Q <= Q + 1, modulo 2^16 (FFFF -> 0000).
REQ-016 FunSel 010 SHALL load: Q <= I.
REQ-017 FunSel 011 SHALL clear: Q <= 0000.
REQ-018 FunSel 100 SHALL clear the register and write the low byte: Q <= {8'h00, I[7:0]}.
REQ-019 FunSel 101 SHALL write the low byte only: Q[7:0] <= I[7:0], with Q[15:8] held.
REQ-020 FunSel 110 SHALL write the high byte only: Q[15:8] <= I[7:0], with Q[7:0] held.
REQ-021 FunSel 111 SHALL sign-extend the low byte: Q <= {8{I[7]}, I[7:0]}.
REQ-022 Multiple enabled registers SHALL all apply the same FunSel in the same cycle.
REQ-023 Each register SHALL act on its own prior value independently; there is no cross-register dependency.
REQ-024 OutASel/OutBSel SHALL decode as: 000 R1, 001 R2, 010 R3, 011 R4, 100 S1, 101 S2, 110 S3, 111 S4.
REQ-025 OutA and OutB SHALL be purely combinational on the current register contents, with no latency.
REQ-026 A register written at an edge SHALL show its pre-edge value on the outputs before that edge and its new value after it (read-before-write, no bypass).
REQ-027 OutA and OutB MAY select the same register simultaneously; both ports SHALL show the identical value.
REQ-028 All-zero RegSel and ScrSel SHALL leave all state unchanged regardless of FunSel and I.

Reset
REQ-029 Reset low SHALL asynchronously force all eight registers to 0000, independent of Clock.
REQ-030 While Reset is low, a clock edge SHALL NOT modify any register, whatever the enables.
REQ-031 After Reset is released, the first rising edge with enables active SHALL perform a normal operation on the 0000 values.
REQ-032 Reset asserted mid-sequence SHALL discard any pending update; outputs SHALL read 0000 immediately.

Verification
REQ-033 Reset low, then high; OutASel=000, OutBSel=111 -> OutA=0000, OutB=0000.
REQ-034 FunSel=010, I=1234, RegSel=1000, edge -> R1=1234; FunSel=001, edge -> R1=1235; FunSel=000, two edges -> R1=1233.
REQ-035 R2=0000, FunSel=000, RegSel=0100, edge -> R2=FFFF; then FunSel=001, edge -> R2=0000.
REQ-036 S1=ABCD, I=0085, ScrSel=1000: FunSel=101 -> S1=AB85; FunSel=110 -> S1=85CD; FunSel=111 -> S1=FF85; FunSel=100 -> S1=0085.
REQ-037 RegSel=1111, ScrSel=1111, FunSel=010, I=00AA, edge -> all eight registers = 00AA; RegSel=ScrSel=0000, FunSel=011, edge -> all remain 00AA.
REQ-038 R3=0042; Reset pulsed low between edges with RegSel=0010 and FunSel=001 -> R3=0000 at once, with no increment at the next edge while Reset is low.
